cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Two-port arbiter that shares one downstream cache/memory port between two upstream requesters, for example an instruction L1 and a data L1 feeding a shared L2. Both sides use the same level-request / one-cycle-response protocol as the cache levels. The arbiter grants one transaction at a time, round-robin on ties, and holds the grant until the downstream response arrives. It latches address and write data at grant and routes the response back only to the granted port.

## Interface
- `ADDR_WIDTH`, 16, address width on all ports
- `DATA_WIDTH`, 32, data width on all ports
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `p0_read_request`, `p1_read_request`  in  1  level read request, held until that port's response
- `p0_write_request`, `p1_write_request`  in  1  level write request, held until that port's response
- `p0_addr`, `p1_addr`  in  ADDR_WIDTH  request address
- `p0_write_data`, `p1_write_data`  in  DATA_WIDTH  write data
- `p0_response`, `p1_response`  out  1  one-cycle completion pulse
- `p0_read_data`, `p1_read_data`  out  DATA_WIDTH  read data, valid while that port's response is high
- `memory_read_request`, `memory_write_request`  out  1  downstream level request
- `memory_addr`  out  ADDR_WIDTH  latched address
- `memory_write_data`  out  DATA_WIDTH  latched write data
- `memory_response`  in  1  downstream completion pulse
- `memory_read_data`  in  DATA_WIDTH  downstream read data, valid with `memory_response`
- `grant_valid`  out  1  a transaction is in flight (ISSUE or RESPOND state)
- `grant_id`  out  1  port owning the current or last grant

## Operation
- States: IDLE, ISSUE, RESPOND.
- A port is "requesting" when its read_request or write_request is high.
- If read and write are both high on one port, it is treated as a write.
- IDLE, transitions:
  - no port requesting: stay in IDLE.
  - exactly one port requesting: grant that port.
  - both ports requesting: grant the port that is not `last_grant`.
- On grant:
  - latch addr, write_data and op type; set `grant_id` and `last_grant`.
  - go to ISSUE.
- ISSUE:
  - drive `memory_read_request` or `memory_write_request` from the latched op, plus latched addr and data.
  - ignore all upstream changes; the latched values are authoritative.
  - when `memory_response` is sampled high: capture `memory_read_data`, go to RESPOND.
- RESPOND:
  - the granted port's response is high for exactly this cycle; its read_data = captured data. Write responses also present the captured value.
  - downstream requests are low.
  - always return to IDLE next cycle.
  - the other port's response stays 0; its read_data holds 0.
- `memory_response` sampled in IDLE or RESPOND is ignored.
- Round-robin: `last_grant` resets to 1, so port 0 wins the first tie. Under continuous contention grants strictly alternate 0,1,0,1.

## Timing
- Reset (sampled at rising edge with `rst`=1), from the next cycle:
  - state IDLE, `last_grant`=1.
  - all request and response outputs are 0; `grant_valid`=0, `grant_id`=0.
  - `memory_addr`, `memory_write_data` and both read_data outputs are 0.
- Reset mid-transaction aborts it immediately:
  - downstream request drops the cycle after the reset edge.
  - no upstream response is ever issued for the aborted transaction.
- Grant edge E0 (request sampled high in IDLE) sets the downstream request high in cycle E0+1. It is registered, with no combinational upstream-to-downstream path.
- `memory_response` sampled at edge E1 ≥ E0+1: downstream request low and `pX_response` high in cycle E1+1.
- Minimum request-to-response latency is 2 cycles, when memory responds in the first ISSUE cycle.
- Next grant is evaluated at edge E1+1, the RESPOND→IDLE edge, earliest downstream request E1+2.
  - A served port still holding its request at that edge is treated as a new request, so requesters must drop the request in the response cycle.
- A request arriving during ISSUE/RESPOND waits, with no loss, until the next IDLE sample.

## Test plan
- P0 read, addr 0x0010, memory replies 0xDEADBEEF after 20 cycles:
  - `memory_read_request` high with addr 0x0010 for 20 cycles.
  - `p0_response` pulses once with 0xDEADBEEF; `p1_response` stays 0.
- P0 and P1 reads (0x0010, 0x0020) raised in the same cycle after reset:
  - P0 is served first, then P1, each getting its own data.
  - `grant_id` sequence 0,1.
- Both ports re-request continuously for 6 transactions:
  - grant order 0,1,0,1,0,1.
  - no port starves, no double response.
- P1 write 0xABCD1234 to 0x0030:
  - `memory_write_request` high with addr 0x0030 and data 0xABCD1234.
  - P1 changes `p1_addr` to 0x0040 mid-ISSUE; `memory_addr` stays 0x0030.
  - a single `p1_response` pulse.
- `rst` asserted during ISSUE:
  - the next cycle has all outputs 0 and state IDLE.
  - a later `memory_response` pulse produces no upstream response.
- `memory_response` pulsed while IDLE with no requests: no upstream response, state stays IDLE.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one downstream cache/memory port between two
// level-request / one-cycle-response upstream ports.
module cache_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_read_request,
  input  logic                  p0_write_request,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  input  logic                  p1_read_request,
  input  logic                  p1_write_request,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  output logic                  p0_response,
  output logic [DATA_WIDTH-1:0] p0_read_data,
  output logic                  p1_response,
  output logic [DATA_WIDTH-1:0] p1_read_data,
  output logic                  memory_read_request,
  output logic                  memory_write_request,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic                  memory_response,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  output logic                  grant_valid,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_id_q, grant_id_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  p0_resp_q, p0_resp_d;
  logic                  p1_resp_q, p1_resp_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;

  logic req0, req1, pick, pick_wr;

  always_comb begin
    req0    = p0_read_request | p0_write_request;
    req1    = p1_read_request | p1_write_request;
    pick    = (req0 && req1) ? ~last_grant_q : req1;
    pick_wr = pick ? p1_write_request : p0_write_request;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_resp_d    = 1'b0;
    p1_resp_d    = 1'b0;
    p0_rdata_d   = '0;
    p1_rdata_d   = '0;

    case (state_q)
      // The RESPOND exit edge arbitrates like IDLE, so back-to-back grants
      // can raise the next downstream request right after the response cycle.
      IDLE, RESPOND: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        if (req0 || req1) begin
          state_d      = ISSUE;
          grant_id_d   = pick;
          last_grant_d = pick;
          addr_d       = pick ? p1_addr : p0_addr;
          wdata_d      = pick ? p1_write_data : p0_write_data;
          mem_wr_d     = pick_wr;
          mem_rd_d     = ~pick_wr;
        end
      end
      ISSUE: begin
        if (memory_response) begin
          state_d  = RESPOND;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (grant_id_q) begin
            p1_resp_d  = 1'b1;
            p1_rdata_d = memory_read_data;
          end else begin
            p0_resp_d  = 1'b1;
            p0_rdata_d = memory_read_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_resp_q    <= 1'b0;
      p1_resp_q    <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_resp_q    <= p0_resp_d;
      p1_resp_q    <= p1_resp_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign memory_read_request  = mem_rd_q;
  assign memory_write_request = mem_wr_q;
  assign memory_addr          = addr_q;
  assign memory_write_data    = wdata_q;
  assign p0_response          = p0_resp_q;
  assign p1_response          = p1_resp_q;
  assign p0_read_data         = p0_rdata_q;
  assign p1_read_data         = p1_rdata_q;
  assign grant_valid          = (state_q != IDLE);
  assign grant_id             = grant_id_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a vector table plus hand-written
// long-latency and contention sequences.
module tb_cache_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_read_request, p0_write_request, p1_read_request, p1_write_request;
  logic [AW-1:0] p0_addr, p1_addr, memory_addr;
  logic [DW-1:0] p0_write_data, p1_write_data, memory_write_data;
  logic          p0_response, p1_response;
  logic [DW-1:0] p0_read_data, p1_read_data, memory_read_data;
  logic          memory_read_request, memory_write_request, memory_response;
  logic          grant_valid, grant_id;

  cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_read_request(p0_read_request), .p0_write_request(p0_write_request),
    .p0_addr(p0_addr), .p0_write_data(p0_write_data),
    .p1_read_request(p1_read_request), .p1_write_request(p1_write_request),
    .p1_addr(p1_addr), .p1_write_data(p1_write_data),
    .p0_response(p0_response), .p0_read_data(p0_read_data),
    .p1_response(p1_response), .p1_read_data(p1_read_data),
    .memory_read_request(memory_read_request), .memory_write_request(memory_write_request),
    .memory_addr(memory_addr), .memory_write_data(memory_write_data),
    .memory_response(memory_response), .memory_read_data(memory_read_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic p0r, p0w; logic [AW-1:0] p0a; logic [DW-1:0] p0d;
    logic p1r, p1w; logic [AW-1:0] p1a; logic [DW-1:0] p1d;
    logic mr; logic [DW-1:0] md;
  } in_t;

  typedef struct packed {
    logic mrd, mwr; logic [AW-1:0] ma; logic [DW-1:0] mwd;
    logic p0r; logic [DW-1:0] p0d;
    logic p1r; logic [DW-1:0] p1d;
    logic gv, gid;
  } out_t;

  typedef struct { in_t i; out_t o; } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic in_t ri(logic r, logic a0r, logic a0w, logic [AW-1:0] a0a, logic [DW-1:0] a0d,
                             logic a1r, logic a1w, logic [AW-1:0] a1a, logic [DW-1:0] a1d,
                             logic mr, logic [DW-1:0] md);
    in_t x;
    x.rst = r; x.p0r = a0r; x.p0w = a0w; x.p0a = a0a; x.p0d = a0d;
    x.p1r = a1r; x.p1w = a1w; x.p1a = a1a; x.p1d = a1d; x.mr = mr; x.md = md;
    return x;
  endfunction

  function automatic out_t ro(logic mrd, logic mwr, logic [AW-1:0] ma, logic [DW-1:0] mwd,
                              logic r0, logic [DW-1:0] d0, logic r1, logic [DW-1:0] d1,
                              logic gv, logic gid);
    out_t x;
    x.mrd = mrd; x.mwr = mwr; x.ma = ma; x.mwd = mwd;
    x.p0r = r0; x.p0d = d0; x.p1r = r1; x.p1d = d1; x.gv = gv; x.gid = gid;
    return x;
  endfunction

  function automatic out_t cur_out();
    return ro(memory_read_request, memory_write_request, memory_addr, memory_write_data,
              p0_response, p0_read_data, p1_response, p1_read_data, grant_valid, grant_id);
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst;
    p0_read_request = x.p0r; p0_write_request = x.p0w; p0_addr = x.p0a; p0_write_data = x.p0d;
    p1_read_request = x.p1r; p1_write_request = x.p1w; p1_addr = x.p1a; p1_write_data = x.p1d;
    memory_response = x.mr; memory_read_data = x.md;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    out_t z, act;
    int   cnt, wait_c;
    int   order[6];

    drive(ri(1, 0,0,0,0, 0,0,0,0, 0,0));
    z = ro(0,0,0,0, 0,0, 0,0, 0,0);

    vecs.push_back('{ri(1, 0,0,0,0, 0,0,0,0, 0,0), z});
    vecs.push_back('{ri(0, 0,0,0,0, 0,0,0,0, 1,'h1111), z});
    vecs.push_back('{ri(0, 1,0,'h10,0, 0,0,0,0, 0,0), ro(1,0,'h10,0, 0,0, 0,0, 1,0)});
    vecs.push_back('{ri(0, 1,0,'h10,0, 0,0,0,0, 1,'hCAFEF00D), ro(0,0,'h10,0, 1,'hCAFEF00D, 0,0, 1,0)});
    vecs.push_back('{ri(0, 0,0,0,0, 0,0,0,0, 0,0), ro(0,0,'h10,0, 0,0, 0,0, 0,0)});
    vecs.push_back('{ri(0, 0,0,0,0, 0,1,'h30,'hABCD1234, 0,0), ro(0,1,'h30,'hABCD1234, 0,0, 0,0, 1,1)});
    vecs.push_back('{ri(0, 0,0,0,0, 0,1,'h40,'h55, 0,0), ro(0,1,'h30,'hABCD1234, 0,0, 0,0, 1,1)});
    vecs.push_back('{ri(0, 0,0,0,0, 0,1,'h40,'h55, 1,'h77), ro(0,0,'h30,'hABCD1234, 0,0, 1,'h77, 1,1)});
    vecs.push_back('{ri(0, 0,0,0,0, 0,0,0,0, 0,0), ro(0,0,'h30,'hABCD1234, 0,0, 0,0, 0,1)});
    vecs.push_back('{ri(0, 1,0,'h100,0, 1,0,'h200,'h5, 0,0), ro(1,0,'h100,0, 0,0, 0,0, 1,0)});
    vecs.push_back('{ri(0, 1,0,'h100,0, 1,0,'h200,'h5, 1,'hA), ro(0,0,'h100,0, 1,'hA, 0,0, 1,0)});
    vecs.push_back('{ri(0, 0,0,0,0, 1,0,'h200,'h5, 0,0), ro(1,0,'h200,'h5, 0,0, 0,0, 1,1)});
    vecs.push_back('{ri(0, 0,0,0,0, 1,0,'h200,'h5, 1,'hB), ro(0,0,'h200,'h5, 0,0, 1,'hB, 1,1)});
    vecs.push_back('{ri(0, 1,1,'h300,'h99, 0,0,0,0, 0,0), ro(0,1,'h300,'h99, 0,0, 0,0, 1,0)});
    vecs.push_back('{ri(1, 1,1,'h300,'h99, 0,0,0,0, 0,0), z});
    vecs.push_back('{ri(0, 0,0,0,0, 0,0,0,0, 1,'hEE), z});
    vecs.push_back('{ri(0, 0,0,0,0, 0,0,0,0, 0,0), z});

    foreach (vecs[k]) begin
      drive(vecs[k].i);
      @(posedge clk); #1;
      act = cur_out();
      nvec++;
      if (act !== vecs[k].o) begin
        nbad++;
        $display("FAIL vec%0d: got %h expected %h", k, act, vecs[k].o);
      end
    end

    // Long-latency read: downstream request held 20 cycles, single response.
    p0_read_request = 1'b1; p0_addr = 'h10;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      chk("long_req", {memory_read_request, memory_addr, p0_response, p1_response},
          {1'b1, 16'h0010, 1'b0, 1'b0});
      if (k == 20) begin memory_response = 1'b1; memory_read_data = 'hDEADBEEF; end
      @(posedge clk); #1;
    end
    memory_response = 1'b0;
    chk("long_resp", {p0_response, p0_read_data, p1_response, memory_read_request},
        {1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
    p0_read_request = 1'b0;
    @(posedge clk); #1;
    chk("long_single", {p0_response, grant_valid}, 2'b00);

    // Continuous contention from reset: strict alternation starting with port 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p0_read_request = 1'b1; p0_addr = 'h10;
    p1_read_request = 1'b1; p1_addr = 'h20;
    cnt = 0; wait_c = 0;
    for (int cyc = 0; cyc < 200 && cnt < 6; cyc++) begin
      @(posedge clk); #1;
      memory_response = 1'b0;
      if (p0_response || p1_response) begin
        chk("cont_onehot", p0_response ^ p1_response, 1);
        order[cnt] = p1_response ? 1 : 0;
        chk("cont_data", p1_response ? p1_read_data : p0_read_data,
            p1_response ? 64'hD0000020 : 64'hD0000010);
        cnt++;
      end
      p0_read_request = !p0_response;
      p1_read_request = !p1_response;
      if (memory_read_request) begin
        if (wait_c == cnt % 3) begin
          memory_response = 1'b1;
          memory_read_data = {16'hD000, memory_addr};
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
    end
    p0_read_request = 1'b0; p1_read_request = 1'b0; memory_response = 1'b0;
    chk("cont_count", cnt, 6);
    for (int i = 0; i < 6; i++)
      if (i < cnt) chk("cont_order", order[i], i % 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
